aes_uart_rx_frame: RTL and testbench



---
 rtl/aes_uart_pkg.sv | 18 +
 rtl/aes_uart_rx_frame_if.sv | 27 ++
 rtl/crc16_serial.sv | 35 +++
 rtl/aes_uart_rx_frame.sv | 154 +++++++++++++++
 tb/tb_aes_uart_rx_frame.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_uart_pkg.sv
// Constants and types shared by the transmit and receive halves of the AES-over-UART link.
package aes_uart_pkg;
  localparam int FRAME_BYTES = 16;
  localparam int BLOCK_W     = 8 * FRAME_BYTES;
  localparam int PAYLOAD_W   = 112;
  localparam int CRC_W       = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'h0000;

  typedef enum logic [2:0] {IDLE, COLLECT, LATCH, CRC_RUN, DONE} rx_state_e;

  // One MSB-first CRC step in the direct (non-augmented) form.
  function automatic logic [CRC_W-1:0] crc16_next(input logic [CRC_W-1:0] crc,
                                                  input logic             bit_in,
                                                  input logic [CRC_W-1:0] poly);
    return {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bit_in) ? poly : '0);
  endfunction
endpackage

// File: rtl/aes_uart_rx_frame_if.sv
// Byte input, decipher loop-back and frame result bundle of the receive frame controller.
interface aes_uart_rx_frame_if;
  import aes_uart_pkg::*;

  logic [7:0]           rx_byte;
  logic                 rx_valid;
  logic [BLOCK_W-1:0]   cipher_block;
  logic [BLOCK_W-1:0]   plain_in;
  logic [PAYLOAD_W-1:0] data_out;
  logic [CRC_W-1:0]     crc_rx;
  logic                 frame_valid;
  logic                 crc_ok;
  logic                 ack;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_byte, rx_valid, plain_in, ack,
    input  cipher_block, data_out, crc_rx, frame_valid, crc_ok, frame_err, overrun, busy
  );

  modport slave (
    input  rx_byte, rx_valid, plain_in, ack,
    output cipher_block, data_out, crc_rx, frame_valid, crc_ok, frame_err, overrun, busy
  );
endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC16 engine, one message bit per enabled cycle, MSB first.
module crc16_serial
  import aes_uart_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = aes_uart_pkg::CRC_POLY,
  parameter logic [CRC_W-1:0] INIT = aes_uart_pkg::CRC_INIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);
  logic [CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = crc16_next(crc_q, bit_in, POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
endmodule

// File: rtl/aes_uart_rx_frame.sv
// Receive frame controller: assembles a cipher block from UART bytes, latches the deciphered
// text, re-checks its CRC bit-serially and holds payload and status until acknowledged.
module aes_uart_rx_frame
  import aes_uart_pkg::BLOCK_W, aes_uart_pkg::PAYLOAD_W, aes_uart_pkg::CRC_W,
         aes_uart_pkg::FRAME_BYTES, aes_uart_pkg::rx_state_e, aes_uart_pkg::IDLE,
         aes_uart_pkg::COLLECT, aes_uart_pkg::LATCH, aes_uart_pkg::CRC_RUN, aes_uart_pkg::DONE;
#(
  parameter int               BYTES    = FRAME_BYTES,
  parameter logic [CRC_W-1:0] CRC_POLY = aes_uart_pkg::CRC_POLY,
  parameter logic [CRC_W-1:0] CRC_INIT = aes_uart_pkg::CRC_INIT,
  parameter int               TIMEOUT  = 100000
) (
  input logic                clk,
  input logic                reset,
  aes_uart_rx_frame_if.slave bus
);
  localparam int CNT_W = $clog2(BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = $clog2(BLOCK_W);

  rx_state_e            state_q, state_d;
  logic [BLOCK_W-1:0]   cipher_q, cipher_d;
  logic [BLOCK_W-1:0]   plain_q, plain_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [PAYLOAD_W-1:0] data_out_q, data_out_d;
  logic [CRC_W-1:0]     crc_rx_q, crc_rx_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 crc_init, crc_en, crc_bit;
  logic [CRC_W-1:0]     crc_value;

  // Payload bits sit above the CRC field, walked from plain[127] down to plain[16].
  assign crc_bit = plain_q[IDX_W'(CRC_W) + bit_idx_q];

  crc16_serial #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .init   (crc_init),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc_value)
  );

  always_comb begin
    state_d     = state_q;
    cipher_d    = cipher_q;
    plain_d     = plain_q;
    count_d     = count_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    data_out_d  = data_out_q;
    crc_rx_d    = crc_rx_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          cipher_d = {cipher_q[BLOCK_W-9:0], bus.rx_byte};
          count_d  = CNT_W'(1);
          timer_d  = '0;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        // A full block leaves COLLECT one cycle later; a byte in that cycle has nowhere to go.
        if (count_q == CNT_W'(BYTES)) begin
          state_d = LATCH;
          if (bus.rx_valid) overrun_d = 1'b1;
        end else if (bus.rx_valid) begin
          cipher_d = {cipher_q[BLOCK_W-9:0], bus.rx_byte};
          count_d  = count_q + CNT_W'(1);
          timer_d  = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          cipher_d    = '0;
          count_d     = '0;
          timer_d     = '0;
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      LATCH: begin
        plain_d   = bus.plain_in;
        crc_init  = 1'b1;
        bit_idx_d = IDX_W'(PAYLOAD_W - 1);
        state_d   = CRC_RUN;
        if (bus.rx_valid) overrun_d = 1'b1;
      end
      CRC_RUN: begin
        crc_en = 1'b1;
        if (bus.rx_valid) overrun_d = 1'b1;
        if (bit_idx_q == '0) begin
          data_out_d = plain_q[BLOCK_W-1 -: PAYLOAD_W];
          crc_rx_d   = plain_q[CRC_W-1:0];
          state_d    = DONE;
        end else begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.rx_valid) overrun_d = 1'b1;
        if (bus.ack) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cipher_q    <= '0;
      plain_q     <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      data_out_q  <= '0;
      crc_rx_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cipher_q    <= cipher_d;
      plain_q     <= plain_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      data_out_q  <= data_out_d;
      crc_rx_q    <= crc_rx_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.cipher_block = cipher_q;
  assign bus.data_out     = data_out_q;
  assign bus.crc_rx       = crc_rx_q;
  assign bus.frame_valid  = (state_q == DONE);
  assign bus.crc_ok       = (state_q == DONE) && (crc_value == plain_q[CRC_W-1:0]);
  assign bus.frame_err    = frame_err_q;
  assign bus.overrun      = overrun_q;
  assign bus.busy         = (state_q == LATCH) || (state_q == CRC_RUN) || (state_q == DONE);
endmodule

// File: tb/tb_aes_uart_rx_frame.sv
// Randomized and directed bench for aes_uart_rx_frame against a timestamp-level frame model.
module tb_aes_uart_rx_frame;
  import aes_uart_pkg::*;

  localparam int TMO = 50;
  localparam int LAT = 114;
  localparam logic [BLOCK_W-1:0]   KEY = 128'h3A94C1F07E25D86B0F1E2D3C4B5A6978;
  localparam logic [PAYLOAD_W-1:0] NOM = 112'hBEEFCAFEBABE1234567890ABCDEF;

  typedef logic [7:0] byte_q_t [$];

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_strobe = 0;
  bit   saw_ferr = 1'b0;

  aes_uart_rx_frame_if bus ();

  aes_uart_rx_frame #(
    .BYTES    (FRAME_BYTES),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT),
    .TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in decipher: the transmitter XORs with KEY, so this is its inverse.
  assign bus.plain_in = bus.cipher_block ^ KEY;

  always #5 clk = ~clk;

  function automatic logic [CRC_W-1:0] model_crc(input byte_q_t msg);
    logic [CRC_W-1:0] c;
    c = CRC_INIT;
    foreach (msg[i])
      for (int b = 7; b >= 0; b--) begin
        if (c[15] ^ msg[i][b]) c = (c << 1) ^ CRC_POLY;
        else                   c = c << 1;
      end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] payload_crc(input logic [PAYLOAD_W-1:0] p);
    byte_q_t q;
    for (int i = 0; i < PAYLOAD_W / 8; i++) q.push_back(p[PAYLOAD_W-1-8*i -: 8]);
    return model_crc(q);
  endfunction

  function automatic logic [BLOCK_W-1:0] tx_cipher(input logic [PAYLOAD_W-1:0] p);
    return {p, payload_crc(p)} ^ KEY;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame model: tracks collected bytes, idle time and when the pending result becomes visible.
  bit                   m_pend = 0, m_good = 0, m_ferr = 0, m_ovr = 0;
  int                   m_n0 = 0, m_ready = 0, m_cnt = 0, m_idle = 0;
  logic [BLOCK_W-1:0]   m_cipher = '0, m_plain = '0;
  logic [PAYLOAD_W-1:0] m_data = '0;
  logic [CRC_W-1:0]     m_crcrx = '0;

  always @(posedge clk) begin
    cyc++;
    m_ferr = 1'b0;
    if (!reset) begin
      m_pend = 0; m_ovr = 0; m_cnt = 0; m_idle = 0; m_good = 0;
      m_cipher = '0; m_plain = '0; m_data = '0; m_crcrx = '0;
    end else if (m_pend) begin
      if (bus.rx_valid) m_ovr = 1'b1;
      if (cyc == m_ready) begin
        m_data  = m_plain[BLOCK_W-1 -: PAYLOAD_W];
        m_crcrx = m_plain[CRC_W-1:0];
      end
      if (bus.ack && cyc > m_ready) begin
        m_pend = 0;
        m_cnt  = 0;
      end
    end else if (bus.rx_valid) begin
      m_cipher = {m_cipher[BLOCK_W-9:0], bus.rx_byte};
      m_cnt++;
      m_idle = 0;
      if (m_cnt == FRAME_BYTES) begin
        m_pend  = 1;
        m_n0    = cyc;
        m_ready = cyc + LAT;
        m_plain = m_cipher ^ KEY;
        m_good  = (payload_crc(m_plain[BLOCK_W-1 -: PAYLOAD_W]) == m_plain[CRC_W-1:0]);
      end
    end else if (m_cnt > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_cnt = 0; m_idle = 0; m_cipher = '0; m_ferr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic fv, bz;
    fv = m_pend && (cyc >= m_ready);
    bz = m_pend && (cyc > m_n0);
    check("ctrl{fv,crc_ok,ferr,ovr,busy}",
          {bus.frame_valid, bus.crc_ok, bus.frame_err, bus.overrun, bus.busy},
          {fv, fv && m_good, m_ferr, m_ovr, bz});
    check("cipher_block", bus.cipher_block, m_cipher);
    check("result{data_out,crc_rx}", {bus.data_out, bus.crc_rx}, {m_data, m_crcrx});
    if (bus.frame_err === 1'b1) saw_ferr = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'($urandom);
  endtask

  task automatic send_bytes(input logic [BLOCK_W-1:0] c, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      put_byte(c[BLOCK_W-1-8*i -: 8]);
      if (i < last) idle(gap);
    end
    if (last == FRAME_BYTES - 1) last_strobe = cyc;
  endtask

  task automatic wait_valid(output int lat);
    int k;
    k = 0;
    while (bus.frame_valid !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    lat = cyc - last_strobe;
    check("frame_valid within bound", bus.frame_valid, 1'b1);
  endtask

  // Waits for the result, checks it against the deciphered block, then acknowledges.
  task automatic take_result(input logic [BLOCK_W-1:0] c, input string tag,
                             input bit byte_in_done, input bit byte_with_ack, input int ack_delay);
    logic [BLOCK_W-1:0] pl;
    logic               good;
    int                 lat;
    pl   = c ^ KEY;
    good = (payload_crc(pl[BLOCK_W-1 -: PAYLOAD_W]) == pl[CRC_W-1:0]);
    wait_valid(lat);
    check({tag, " latency"}, lat, LAT);
    check({tag, " data_out"}, bus.data_out, pl[BLOCK_W-1 -: PAYLOAD_W]);
    check({tag, " crc_rx"}, bus.crc_rx, pl[CRC_W-1:0]);
    check({tag, " crc_ok"}, bus.crc_ok, good);
    $display("frame %s: data_out=%h crc_rx=%h crc_ok=%0b latency=%0d overrun=%0b",
             tag, bus.data_out, bus.crc_rx, bus.crc_ok, lat, bus.overrun);
    if (byte_in_done) begin
      put_byte(8'hA5);
      check({tag, " overrun after DONE byte"}, bus.overrun, 1'b1);
      check({tag, " data_out held"}, bus.data_out, pl[BLOCK_W-1 -: PAYLOAD_W]);
    end
    idle(ack_delay);
    bus.ack = 1'b1;
    if (byte_with_ack) begin
      bus.rx_byte  = 8'h3C;
      bus.rx_valid = 1'b1;
    end
    tick();
    bus.ack      = 1'b0;
    bus.rx_valid = 1'b0;
    check({tag, " frame_valid after ack"}, bus.frame_valid, 1'b0);
  endtask

  initial begin
    byte_q_t              q;
    logic [BLOCK_W-1:0]   c;
    logic [PAYLOAD_W-1:0] p;
    int                   t5, k;

    bus.rx_byte  = '0;
    bus.rx_valid = 1'b0;
    bus.ack      = 1'b0;

    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model crc of 123456789", model_crc(q), 16'hFEE8);
    q = '{8'h01};
    check("model crc of 01", model_crc(q), 16'h8005);

    idle(3);
    check("reset frame_valid", bus.frame_valid, 1'b0);
    check("reset busy/overrun/ferr", {bus.busy, bus.overrun, bus.frame_err}, 3'b000);
    check("reset cipher_block", bus.cipher_block, '0);
    check("reset data_out/crc_rx", {bus.data_out, bus.crc_rx}, '0);
    reset = 1'b1;
    idle(2);

    // Nominal frame
    c = tx_cipher(NOM);
    send_bytes(c, 0, 15, 10);
    check("nominal cipher_block", bus.cipher_block, c);
    take_result(c, "nominal", 1'b0, 1'b0, 2);
    check("nominal data_out literal", bus.data_out, NOM);

    // Corrupted CRC: bit 0 of the last byte flipped
    c[0] = ~c[0];
    send_bytes(c, 0, 15, 10);
    take_result(c, "corrupt", 1'b0, 1'b0, 0);
    check("corrupt data_out literal", bus.data_out, NOM);

    // Timeout after 5 bytes
    c = tx_cipher(112'h0123456789ABCDEF0011223344);
    send_bytes(c, 0, 4, 2);
    t5 = cyc;
    k  = 0;
    while (bus.frame_err !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("timeout frame_err seen", bus.frame_err, 1'b1);
    check("timeout frame_err cycle", cyc - t5, TMO);
    check("timeout cipher cleared", bus.cipher_block, '0);
    tick();
    check("timeout frame_err one pulse", bus.frame_err, 1'b0);
    send_bytes(c, 0, 15, 1);
    take_result(c, "after-timeout", 1'b0, 1'b0, 1);

    // Timeout boundary: 6th byte lands on the last allowed cycle
    saw_ferr = 1'b0;
    p = 112'hFACEB00C0000FFFF1234DEADBEEF;
    c = tx_cipher(p);
    send_bytes(c, 0, 4, 3);
    idle(TMO - 1);
    send_bytes(c, 5, 15, 0);
    check("boundary no frame_err", saw_ferr, 1'b0);
    take_result(c, "boundary", 1'b0, 1'b0, 0);

    // Overrun during CRC_RUN and DONE
    c = tx_cipher(112'h5555AAAA5555AAAA5555AAAA5555);
    send_bytes(c, 0, 15, 2);
    idle(20);
    put_byte(8'h77);
    check("overrun in CRC_RUN", bus.overrun, 1'b1);
    check("busy in CRC_RUN", bus.busy, 1'b1);
    take_result(c, "overrun", 1'b1, 1'b0, 1);
    check("overrun sticky after ack", bus.overrun, 1'b1);
    c = tx_cipher(NOM ^ 112'h1);
    send_bytes(c, 0, 15, 0);
    take_result(c, "post-overrun", 1'b0, 1'b0, 0);

    // Reset mid CRC_RUN at bit 50
    c = tx_cipher(112'h13579BDF02468ACE0F0F0F0F0F0F);
    send_bytes(c, 0, 15, 1);
    idle(63);
    check("busy before reset", bus.busy, 1'b1);
    reset = 1'b0;
    tick();
    check("mid-reset ctrl{fv,ok,ferr,ovr,busy}",
          {bus.frame_valid, bus.crc_ok, bus.frame_err, bus.overrun, bus.busy}, 5'b0);
    check("mid-reset cipher_block", bus.cipher_block, '0);
    check("mid-reset data_out/crc_rx", {bus.data_out, bus.crc_rx}, '0);
    reset = 1'b1;
    idle(2);
    send_bytes(c, 0, 15, 1);
    take_result(c, "after-reset", 1'b0, 1'b0, 0);

    // Randomized frames
    for (int t = 0; t < 8; t++) begin
      string tag;
      int    flip;
      p    = PAYLOAD_W'({$urandom(), $urandom(), $urandom(), $urandom()});
      c    = tx_cipher(p);
      flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BLOCK_W - 1)) : -1;
      if (flip >= 0) c = c ^ (BLOCK_W'(1) << flip);
      if ($urandom_range(0, 1) == 1) begin
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
      end
      send_bytes(c, 0, 15, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) begin
        idle(int'($urandom_range(1, 100)));
        put_byte(8'($urandom));
      end
      tag = $sformatf("random%0d", t);
      take_result(c, tag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 5)));
      idle(int'($urandom_range(0, 4)));
    end

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
